multi_border_collision: RTL
===========================

MULTI_BORDER_COLLISION -- requirements
Module: multi_border_collision

Interface
REQ-001 SHALL have parameter N_BALLS, default 4: number of independent ball channels (1..16).
REQ-002 SHALL have parameter W, default 11: signed width of every position and velocity.
REQ-003 SHALL have parameters TOP_OFFSET 32, DOWN_OFFSET 440, LEFT_OFFSET 32, RIGHT_OFFSET 600: border thresholds in pixels.
REQ-004 SHALL have parameter LOCK_FRAMES, default 3: frames a channel ignores repeat hits after a reflection (1..15).
REQ-005 SHALL have parameter DAMP_SHIFT, default 3: damping shift, used only under REQ-024.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-009 SHALL have port borderDR, input, 1: border pixel drawing request.
REQ-010 SHALL have port ballDR, input, N_BALLS: per-channel ball drawing request.
REQ-011 SHALL have ports ballPosX and ballPosY, input, N_BALLS*W each: packed signed top-left positions, channel i at bits [i*W +: W].
REQ-012 SHALL have ports ballVelX and ballVelY, input, N_BALLS*W each: packed signed velocities.
REQ-013 SHALL have ports ballVelXOut and ballVelYOut, output, N_BALLS*W each: registered corrected velocities.
REQ-014 SHALL have port collisionOccurred, output, N_BALLS: one-cycle hit pulse per channel.
REQ-015 SHALL have port sideHit, output, N_BALLS*4: sticky side mask per channel, {top,down,left,right}.

Function
REQ-016 SHALL give each channel its own FSM with states IDLE, LOCK and WAIT_CLEAR, plus a 4-bit frame counter.
REQ-017 SHALL detect a hit on channel i when ballDR[i] && borderDR && state==IDLE, evaluated every clk.
REQ-018 SHALL decide sides on a hit as follows:
- left = posX<=LEFT_OFFSET && velX<0
- right = posX>=RIGHT_OFFSET && velX>0
- top = posY<=TOP_OFFSET && velY<0
- down = posY>=DOWN_OFFSET && velY>0
- each comparison is signed.
REQ-019 SHALL, when a hit sets at least one side, do all of the following:
- negate the matching axis (both axes if both match) into the output register one cycle later
- pulse collisionOccurred[i] for exactly one cycle
- load sideHit[i]
- load the counter with LOCK_FRAMES
- enter LOCK.
REQ-020 SHALL treat a hit with no side set (ball moving away, or a corner pixel inside the thresholds) as no collision: no pulse, velocities pass through, state stays IDLE.
REQ-021 SHALL, when no reflection is being applied, register ballVelXOut/ballVelYOut = ballVelX/ballVelY with one-cycle latency.
REQ-022 SHALL negate with saturation: input -2^(W-1) gives output 2^(W-1)-1.
REQ-023 SHALL run the LOCK and WAIT_CLEAR states as follows:
- LOCK: decrement the counter on each startOfFrame and ignore overlaps; when the counter reaches 0, go to WAIT_CLEAR.
- WAIT_CLEAR: return to IDLE on the first startOfFrame of a frame in which channel i had no overlap.
- sideHit[i] holds until that return to IDLE, then clears.
- Simultaneous hits on several channels are handled independently in the same cycle.

Configuration
REQ-024 SHALL, with BORDER_DAMPING_EN defined, output the reflected component as -(v - (v>>>DAMP_SHIFT)), saturated per REQ-022; without the macro, output the plain saturated negation; non-reflected components are unaffected in both builds.

Reset
REQ-025 SHALL, while resetN is low, force all of the following:
- ballVelXOut, ballVelYOut, collisionOccurred and sideHit to 0
- every FSM to IDLE
- every counter to 0.
REQ-026 SHALL, on a reset asserted mid-LOCK, abandon the lockout with no residual pulse, and treat the first post-reset overlap as a fresh hit.

Verification
REQ-027 SHALL cover: ch0 posX=20, velX=-5, velY=2, ballDR[0]=borderDR=1 -> next cycle velXOut0=+5, velYOut0=2, collisionOccurred=0001, sideHit0=0010.
REQ-028 SHALL cover: ch1 posX=20, posY=20, velX=-3, velY=-4 (corner) -> velXOut1=3, velYOut1=4, sideHit1=1010, one pulse.
REQ-029 SHALL cover: ch2 posX=20, velX=+6 (leaving) with overlap -> velXOut2=6, no pulse, state stays IDLE.
REQ-030 SHALL cover: overlap held for 5 frames with LOCK_FRAMES=3 -> exactly one pulse; IDLE only after the first clear frame.
REQ-031 SHALL cover: velX=-1024 at left border -> velXOut=+1023; with BORDER_DAMPING_EN and velX=-16 -> +14.
REQ-032 SHALL cover: resetN pulsed low during LOCK -> all outputs 0; a re-hit next frame gives a new pulse.

Source files
------------

// File: rtl/multi_border_collision.sv
// multi_border_collision
//   Border collision handling for N_BALLS independent ball channels. When a
//   ball and the border are drawn on the same pixel, each channel decides
//   which sides it hit. It reflects the matching velocity components and then
//   locks out repeat hits for a few frames.
//
//   Optional feature: define BORDER_DAMPING_EN to damp reflected components
//   by v>>>DAMP_SHIFT before negation.
//
//   Ports
//     clk, resetN          clock, asynchronous active-low reset
//     startOfFrame         one-cycle pulse per video frame
//     borderDR             border pixel drawing request
//     ballDR[N]            per-channel ball drawing request
//     ballPosX/Y[N*W]      packed signed top-left positions, ch i at [i*W +: W]
//     ballVelX/Y[N*W]      packed signed velocities
//     ballVelX/YOut[N*W]   registered (possibly reflected) velocities
//     collisionOccurred[N] one-cycle hit pulse per channel
//     sideHit[N*4]         sticky {top,down,left,right} per channel

// Per-channel collision FSM.
module mbc_lane #(
  parameter int W            = 11,
  parameter int TOP_OFFSET   = 32,
  parameter int DOWN_OFFSET  = 440,
  parameter int LEFT_OFFSET  = 32,
  parameter int RIGHT_OFFSET = 600,
  parameter int LOCK_FRAMES  = 3,
  parameter int DAMP_SHIFT   = 3
)(
  input  logic                clk,
  input  logic                resetN,
  input  logic                sof_i,
  input  logic                ovl_i,     // ball and border overlap this pixel
  input  logic signed [W-1:0] pos_x_i,
  input  logic signed [W-1:0] pos_y_i,
  input  logic signed [W-1:0] vel_x_i,
  input  logic signed [W-1:0] vel_y_i,
  output logic signed [W-1:0] vel_x_o,
  output logic signed [W-1:0] vel_y_o,
  output logic                hit_o,
  output logic [3:0]          side_o
);

`ifdef BORDER_DAMPING_EN
  localparam bit DAMP_EN = 1'b1;
`else
  localparam bit DAMP_EN = 1'b0;
`endif

  localparam logic signed [W-1:0] TOP_T   = TOP_OFFSET[W-1:0];
  localparam logic signed [W-1:0] DOWN_T  = DOWN_OFFSET[W-1:0];
  localparam logic signed [W-1:0] LEFT_T  = LEFT_OFFSET[W-1:0];
  localparam logic signed [W-1:0] RIGHT_T = RIGHT_OFFSET[W-1:0];
  localparam logic signed [W-1:0] MIN_V   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_V   = {1'b0, {(W-1){1'b1}}};
  localparam logic [3:0]          LOCK_N  = LOCK_FRAMES[3:0];

  typedef enum logic [1:0] {IDLE, LOCK, WAIT_CLEAR} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                ovl_q;   // any overlap seen since the last frame start
  logic signed [W-1:0] vx_q, vy_q;
  logic                hit_q;
  logic [3:0]          side_q;

  // Negation saturates so the most negative value maps to the most positive.
  function automatic logic signed [W-1:0] reflect(input logic signed [W-1:0] v);
    logic signed [W-1:0] m;
    m = DAMP_EN ? v - (v >>> DAMP_SHIFT) : v;
    return (m == MIN_V) ? MAX_V : -m;
  endfunction

  logic       neg_x, pos_vx, neg_y, pos_vy;
  logic [3:0] sides_d;
  logic       refl_x_d, refl_y_d;

  always_comb begin
    neg_x    = vel_x_i[W-1];
    pos_vx   = !vel_x_i[W-1] && (vel_x_i != '0);
    neg_y    = vel_y_i[W-1];
    pos_vy   = !vel_y_i[W-1] && (vel_y_i != '0);
    sides_d  = {(pos_y_i <= TOP_T)   && neg_y,
                (pos_y_i >= DOWN_T)  && pos_vy,
                (pos_x_i <= LEFT_T)  && neg_x,
                (pos_x_i >= RIGHT_T) && pos_vx};
    refl_x_d = sides_d[1] | sides_d[0];
    refl_y_d = sides_d[3] | sides_d[2];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovl_q   <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      hit_q   <= 1'b0;
      side_q  <= '0;
    end else begin
      hit_q <= 1'b0;
      vx_q  <= vel_x_i;
      vy_q  <= vel_y_i;
      // The frame-start cycle belongs to the new frame.
      ovl_q <= sof_i ? ovl_i : (ovl_q | ovl_i);
      case (state_q)
        IDLE: begin
          // An overlap with no qualifying side (ball moving away, or an
          // inner corner pixel) is not a collision.
          if (ovl_i && (sides_d != 4'b0)) begin
            if (refl_x_d) vx_q <= reflect(vel_x_i);
            if (refl_y_d) vy_q <= reflect(vel_y_i);
            hit_q   <= 1'b1;
            side_q  <= sides_d;
            cnt_q   <= LOCK_N;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (sof_i) begin
            cnt_q <= (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            if (cnt_q <= 4'd1) state_q <= WAIT_CLEAR;
          end
        end
        WAIT_CLEAR: begin
          // ovl_q still covers the frame that is just ending.
          if (sof_i && !ovl_q) begin
            state_q <= IDLE;
            side_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vel_x_o = vx_q;
  assign vel_y_o = vy_q;
  assign hit_o   = hit_q;
  assign side_o  = side_q;

endmodule

module multi_border_collision #(
  parameter int N_BALLS      = 4,
  parameter int W            = 11,
  parameter int TOP_OFFSET   = 32,
  parameter int DOWN_OFFSET  = 440,
  parameter int LEFT_OFFSET  = 32,
  parameter int RIGHT_OFFSET = 600,
  parameter int LOCK_FRAMES  = 3,
  parameter int DAMP_SHIFT   = 3
)(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 borderDR,
  input  logic [N_BALLS-1:0]   ballDR,
  input  logic [N_BALLS*W-1:0] ballPosX,
  input  logic [N_BALLS*W-1:0] ballPosY,
  input  logic [N_BALLS*W-1:0] ballVelX,
  input  logic [N_BALLS*W-1:0] ballVelY,
  output logic [N_BALLS*W-1:0] ballVelXOut,
  output logic [N_BALLS*W-1:0] ballVelYOut,
  output logic [N_BALLS-1:0]   collisionOccurred,
  output logic [N_BALLS*4-1:0] sideHit
);

  for (genvar i = 0; i < N_BALLS; i++) begin : g_lane
    mbc_lane #(
      .W(W), .TOP_OFFSET(TOP_OFFSET), .DOWN_OFFSET(DOWN_OFFSET),
      .LEFT_OFFSET(LEFT_OFFSET), .RIGHT_OFFSET(RIGHT_OFFSET),
      .LOCK_FRAMES(LOCK_FRAMES), .DAMP_SHIFT(DAMP_SHIFT)
    ) u_lane (
      .clk     (clk),
      .resetN  (resetN),
      .sof_i   (startOfFrame),
      .ovl_i   (ballDR[i] & borderDR),
      .pos_x_i (ballPosX[i*W +: W]),
      .pos_y_i (ballPosY[i*W +: W]),
      .vel_x_i (ballVelX[i*W +: W]),
      .vel_y_i (ballVelY[i*W +: W]),
      .vel_x_o (ballVelXOut[i*W +: W]),
      .vel_y_o (ballVelYOut[i*W +: W]),
      .hit_o   (collisionOccurred[i]),
      .side_o  (sideHit[i*4 +: 4])
    );
  end

endmodule
